// File: rtl/pwm_measure_pkg.sv
// Shared constants, encodings and helpers for the servo PWM decoder and generator.
package pwm_pkg;

   localparam int CNT_W = 20;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Full-scale timing at 100 MHz.
   localparam int TIMEOUT_CYC = 600000;
   localparam int POS_L_MIN   = 100000;   // left band   [L_MIN, N_MIN)
   localparam int POS_N_MIN   = 130000;   // neutral band [N_MIN, N_MAX]
   localparam int POS_N_MAX   = 170000;
   localparam int POS_R_MAX   = 200000;   // right band  (N_MAX, R_MAX]

   // Generator high times for the three nominal servo positions.
   localparam int GEN_L = 110000;
   localparam int GEN_N = 150000;
   localparam int GEN_R = 190000;

   typedef logic [2:0] pos_t;
   localparam pos_t POS_NONE  = 3'b000;
   localparam pos_t POS_LEFT  = 3'b100;
   localparam pos_t POS_NEUT  = 3'b010;
   localparam pos_t POS_RIGHT = 3'b001;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW
   } state_t;

   // Map a high-pulse width onto a position code using the supplied band edges.
   function automatic pos_t decode_pos(input logic [CNT_W-1:0] w,
                                       input int l_min, input int n_min,
                                       input int n_max, input int r_max);
      int wi;
      wi = int'(w);
      if (wi >= l_min && wi < n_min)
         return POS_LEFT;
      else if (wi >= n_min && wi <= n_max)
         return POS_NEUT;
      else if (wi > n_max && wi <= r_max)
         return POS_RIGHT;
      else
         return POS_NONE;
   endfunction

endpackage

// File: rtl/pwm_measure_if.sv
// Measurement bus: PWM line in, pulse/period results and status out.
interface pwm_measure_if;
   import pwm_pkg::*;

   logic             PWM_IN;
   logic [CNT_W-1:0] HIGH_CNT;
   logic [CNT_W-1:0] PERIOD_CNT;
   logic             MEAS_VALID;
   pos_t             POS;
   logic             TIMEOUT;
   logic             LEVEL;

   // The master drives the PWM line and consumes results.
   modport master (output PWM_IN,
                   input  HIGH_CNT, PERIOD_CNT, MEAS_VALID, POS, TIMEOUT, LEVEL);

   // The decoder consumes the PWM line and produces results.
   modport slave  (input  PWM_IN,
                   output HIGH_CNT, PERIOD_CNT, MEAS_VALID, POS, TIMEOUT, LEVEL);
endinterface

// File: rtl/pwm_measure_sync_edge.sv
// Two-flop synchronizer for an asynchronous line plus a history flop for edge detect.
module sync_edge (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic hist_q;

   // Shift the raw line through meta -> sync -> history.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         hist_q <= 1'b0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         hist_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign rise_o  = sync_q & ~hist_q;
   assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/pwm_measure.sv
// Servo PWM decoder: measures high time and rising-to-rising period, classifies
// the position and flags a line that has stopped toggling.
module pwm_measure
   import pwm_pkg::*;
#(
   parameter int TIMEOUT_CYC_P = TIMEOUT_CYC,
   parameter int POS_L_MIN_P   = POS_L_MIN,
   parameter int POS_N_MIN_P   = POS_N_MIN,
   parameter int POS_N_MAX_P   = POS_N_MAX,
   parameter int POS_R_MAX_P   = POS_R_MAX
) (
   input  logic         CLK,
   input  logic         RST,
   pwm_measure_if.slave bus
);

   logic             level;
   logic             rise;
   logic             fall;

   state_t           state_q,      state_d;
   logic [CNT_W-1:0] cnt_q,        cnt_d;
   logic [CNT_W-1:0] high_cap_q,   high_cap_d;
   logic [CNT_W-1:0] high_cnt_q,   high_cnt_d;
   logic [CNT_W-1:0] period_q,     period_d;
   pos_t             pos_q,        pos_d;
   logic             valid_q,      valid_d;
   logic             timeout_q,    timeout_d;

   logic [CNT_W-1:0] cnt_inc;
   logic             to_hit;

   sync_edge u_sync (
      .clk_i   (CLK),
      .rst_i   (RST),
      .async_i (bus.PWM_IN),
      .level_o (level),
      .rise_o  (rise),
      .fall_o  (fall)
   );

   // The counter is cleared on the rise-detect cycle, so the elapsed count at
   // any later edge is cnt_q + 1; capturing cnt_inc gives exact widths.
   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
   assign to_hit  = int'(cnt_inc) >= TIMEOUT_CYC_P;

   // State and result registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         high_cap_q <= '0;
         high_cnt_q <= '0;
         period_q   <= '0;
         pos_q      <= POS_NONE;
         valid_q    <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         high_cap_q <= high_cap_d;
         high_cnt_q <= high_cnt_d;
         period_q   <= period_d;
         pos_q      <= pos_d;
         valid_q    <= valid_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next-state logic; edges take priority over the timeout check.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_inc;
      high_cap_d = high_cap_q;
      high_cnt_d = high_cnt_q;
      period_d   = period_q;
      pos_d      = pos_q;
      valid_d    = 1'b0;
      timeout_d  = timeout_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rise) begin
               state_d = ST_HIGH;
            end
         end
         ST_HIGH: begin
            if (fall) begin
               state_d    = ST_LOW;
               high_cap_d = cnt_inc;
            end else if (to_hit) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               timeout_d = 1'b1;
               pos_d     = POS_NONE;
            end
         end
         ST_LOW: begin
            if (rise) begin
               state_d    = ST_HIGH;
               cnt_d      = '0;
               period_d   = cnt_inc;
               high_cnt_d = high_cap_q;
               pos_d      = decode_pos(high_cap_q, POS_L_MIN_P, POS_N_MIN_P,
                                       POS_N_MAX_P, POS_R_MAX_P);
               valid_d    = 1'b1;
               timeout_d  = 1'b0;
            end else if (to_hit) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               timeout_d = 1'b1;
               pos_d     = POS_NONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.HIGH_CNT   = high_cnt_q;
   assign bus.PERIOD_CNT = period_q;
   assign bus.POS        = pos_q;
   assign bus.MEAS_VALID = valid_q;
   assign bus.TIMEOUT    = timeout_q;
   assign bus.LEVEL      = level;

endmodule

// File: tb/tb_pwm_measure.sv
// Bench for pwm_measure with time constants scaled down by 1000.
module tb_pwm_measure;
   import pwm_pkg::*;

   localparam int T_TO  = 600;
   localparam int L_MIN = 100;
   localparam int N_MIN = 130;
   localparam int N_MAX = 170;
   localparam int R_MAX = 200;
   localparam int G_L   = 110;
   localparam int G_N   = 150;
   localparam int G_R   = 190;

   logic CLK = 1'b0;
   logic RST;
   pwm_measure_if bus();

   pwm_measure #(
      .TIMEOUT_CYC_P (T_TO),
      .POS_L_MIN_P   (L_MIN),
      .POS_N_MIN_P   (N_MIN),
      .POS_N_MAX_P   (N_MAX),
      .POS_R_MAX_P   (R_MAX)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int   h;
      int   p;
      pos_t pos;
   } meas_t;

   meas_t got_q[$];
   meas_t exp_q[$];

   // Record every strobe seen on the falling edge.
   always @(negedge CLK) begin
      if (bus.MEAS_VALID === 1'b1)
         got_q.push_back('{int'(bus.HIGH_CNT), int'(bus.PERIOD_CNT), bus.POS});
   end

   // Reference position classification from the band edges.
   function automatic pos_t model_pos(input int w);
      if (w >= L_MIN && w < N_MIN) return 3'b100;
      if (w >= N_MIN && w <= N_MAX) return 3'b010;
      if (w > N_MAX && w <= R_MAX) return 3'b001;
      return 3'b000;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic pin_for(input logic lvl, input int n);
      bus.PWM_IN = lvl;
      cycles(n);
   endtask

   // One PWM cycle starting with a rise: high w, low p-w.
   task automatic pwm_cycle(input int w, input int p);
      pin_for(1'b1, w);
      pin_for(1'b0, p - w);
      exp_q.push_back('{w, p, model_pos(w)});
   endtask

   task automatic do_reset();
      RST = 1'b1;
      bus.PWM_IN = 1'b0;
      cycles(3);
      RST = 1'b0;
      cycles(2);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      bus.PWM_IN = 1'b1;
      cycles(4);
      checks += 6;
      if (bus.HIGH_CNT !== 20'd0) begin errors++; $display("FAIL reset_high got %0d want 0", bus.HIGH_CNT); end
      if (bus.PERIOD_CNT !== 20'd0) begin errors++; $display("FAIL reset_period got %0d want 0", bus.PERIOD_CNT); end
      if (bus.MEAS_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.MEAS_VALID); end
      if (bus.POS !== 3'b000) begin errors++; $display("FAIL reset_pos got %b want 000", bus.POS); end
      if (bus.TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", bus.TIMEOUT); end
      if (bus.LEVEL !== 1'b0) begin errors++; $display("FAIL reset_level got %b want 0", bus.LEVEL); end
      $display("test_reset done");
   endtask

   // Compare all recorded strobes with the expected list.
   task automatic test_compare_strobes(input string name);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL %s_count got %0d want %0d", name, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i].h !== exp_q[i].h || got_q[i].p !== exp_q[i].p || got_q[i].pos !== exp_q[i].pos) begin
            errors++;
            $display("FAIL %s_meas%0d got h=%0d p=%0d pos=%b want h=%0d p=%0d pos=%b", name, i,
                     got_q[i].h, got_q[i].p, got_q[i].pos, exp_q[i].h, exp_q[i].p, exp_q[i].pos);
         end else begin
            $display("%s meas%0d h=%0d p=%0d pos=%b ok", name, i, got_q[i].h, got_q[i].p, got_q[i].pos);
         end
      end
   endtask

   task automatic test_neutral();
      do_reset();
      pwm_cycle(G_N, 524);
      pwm_cycle(G_N, 524);
      pin_for(1'b1, 6);
      test_compare_strobes("neutral");
      cycles(20);
      checks += 2;
      if (bus.HIGH_CNT !== 20'(G_N)) begin errors++; $display("FAIL hold_high got %0d want %0d", bus.HIGH_CNT, G_N); end
      if (bus.POS !== 3'b010) begin errors++; $display("FAIL hold_pos got %b want 010", bus.POS); end
   endtask

   task automatic test_positions();
      do_reset();
      pwm_cycle(G_L, 400);
      pwm_cycle(G_R, 400);
      pwm_cycle(90, 400);
      pin_for(1'b1, 6);
      test_compare_strobes("positions");
   endtask

   task automatic test_pos_boundaries();
      int ws[7] = '{99, 100, 129, 130, 171, 200, 201};
      do_reset();
      foreach (ws[i]) pwm_cycle(ws[i], 350);
      pin_for(1'b1, 6);
      test_compare_strobes("bounds");
   endtask

   task automatic test_latency();
      do_reset();
      pwm_cycle(G_N, 300);
      bus.PWM_IN = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge CLK);
         #1;
         checks++;
         if (bus.MEAS_VALID !== (k == 3)) begin
            errors++;
            $display("FAIL latency_edge%0d got %b want %b", k, bus.MEAS_VALID, (k == 3));
         end else begin
            $display("latency edge%0d valid=%b ok", k, bus.MEAS_VALID);
         end
      end
   endtask

   task automatic test_timeout_low();
      do_reset();
      pwm_cycle(G_N, 400);
      pin_for(1'b1, 130);
      pin_for(1'b0, 400);
      checks++;
      if (bus.TIMEOUT !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", bus.TIMEOUT); end
      pin_for(1'b0, 300);
      checks += 5;
      if (bus.TIMEOUT !== 1'b1) begin errors++; $display("FAIL timeout_low got %b want 1", bus.TIMEOUT); end
      if (bus.LEVEL !== 1'b0) begin errors++; $display("FAIL timeout_level got %b want 0", bus.LEVEL); end
      if (bus.POS !== 3'b000) begin errors++; $display("FAIL timeout_pos got %b want 000", bus.POS); end
      if (bus.HIGH_CNT !== 20'(G_N)) begin errors++; $display("FAIL timeout_high got %0d want %0d", bus.HIGH_CNT, G_N); end
      if (bus.PERIOD_CNT !== 20'd400) begin errors++; $display("FAIL timeout_period got %0d want 400", bus.PERIOD_CNT); end
      pwm_cycle(120, 400);
      pin_for(1'b1, 6);
      checks++;
      if (bus.TIMEOUT !== 1'b0) begin errors++; $display("FAIL timeout_clear got %b want 0", bus.TIMEOUT); end
      test_compare_strobes("timeout_low");
   endtask

   task automatic test_timeout_high();
      do_reset();
      pin_for(1'b1, 700);
      checks += 4;
      if (bus.TIMEOUT !== 1'b1) begin errors++; $display("FAIL stuckhi_timeout got %b want 1", bus.TIMEOUT); end
      if (bus.LEVEL !== 1'b1) begin errors++; $display("FAIL stuckhi_level got %b want 1", bus.LEVEL); end
      if (bus.POS !== 3'b000) begin errors++; $display("FAIL stuckhi_pos got %b want 000", bus.POS); end
      if (got_q.size() != 0) begin errors++; $display("FAIL stuckhi_strobes got %0d want 0", got_q.size()); end
      $display("timeout_high done");
   endtask

   task automatic test_reset_mid();
      do_reset();
      pwm_cycle(G_N, 400);
      pin_for(1'b1, 50);
      RST = 1'b1;
      bus.PWM_IN = 1'b0;
      cycles(1);
      RST = 1'b0;
      checks += 4;
      if (bus.HIGH_CNT !== 20'd0) begin errors++; $display("FAIL midrst_high got %0d want 0", bus.HIGH_CNT); end
      if (bus.PERIOD_CNT !== 20'd0) begin errors++; $display("FAIL midrst_period got %0d want 0", bus.PERIOD_CNT); end
      if (bus.POS !== 3'b000) begin errors++; $display("FAIL midrst_pos got %b want 000", bus.POS); end
      if (bus.MEAS_VALID !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.MEAS_VALID); end
      got_q.delete();
      exp_q.delete();
      pin_for(1'b0, 20);
      pwm_cycle(N_MAX, 450);
      pin_for(1'b1, 6);
      test_compare_strobes("reset_mid");
   endtask

   task automatic test_random();
      int w;
      int p;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         w = $urandom_range(240, 60);
         p = $urandom_range(590, w + 10);
         pwm_cycle(w, p);
      end
      pin_for(1'b1, 6);
      test_compare_strobes("random");
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1;
      bus.PWM_IN = 1'b0;
      test_reset();
      test_neutral();
      test_positions();
      test_pos_boundaries();
      test_latency();
      test_timeout_low();
      test_timeout_high();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_measure.md
PWM_MEASURE -- requirements
Module: pwm_measure

Interface
REQ-001 CLK  input  1  system clock (100 MHz); all logic on posedge CLK.
REQ-002 RST  input  1  reset, synchronous, active-high.
REQ-003 PWM_IN  input  1  asynchronous servo PWM line to be decoded.
REQ-004 HIGH_CNT  output  20  width of last complete high pulse, in CLK cycles.
REQ-005 PERIOD_CNT  output  20  rising-to-rising period of last complete cycle, in CLK cycles.
REQ-006 MEAS_VALID  output  1  one-cycle strobe; HIGH_CNT/PERIOD_CNT/POS updated in the same cycle.
REQ-007 POS  output  3  decoded position: 100 left, 010 neutral, 001 right, 000 invalid/none.
REQ-008 TIMEOUT  output  1  sticky flag: no PWM_IN edge for TIMEOUT_CYC cycles.
REQ-009 LEVEL  output  1  synchronized PWM_IN level; meaningful when TIMEOUT=1 (0 stuck low, 1 stuck high).

Function
REQ-010 PWM_IN SHALL pass through a 2-FF synchronizer plus one history register; rise = sync & ~hist, fall = ~sync & hist.
REQ-011 FSM states SHALL be IDLE, HIGH, LOW.
REQ-012 IDLE: ignore level; on rise -> HIGH, cycle counter CNT loaded 0.
REQ-013 HIGH: CNT increments each cycle; on fall -> LOW, capture CNT into internal high register, CNT loaded 0... no: CNT keeps counting from the rise (CNT measures period).
REQ-014 LOW: CNT increments; on rise -> HIGH, PERIOD_CNT <= CNT, HIGH_CNT <= captured high value, POS updated, MEAS_VALID=1 for exactly one cycle, CNT loaded 0, TIMEOUT cleared.
REQ-015 Pin high W cycles, period P cycles SHALL report HIGH_CNT=W, PERIOD_CNT=P exactly (no ±1 error).
REQ-016 Latency PWM_IN rising edge -> MEAS_VALID SHALL be fixed at 3 CLK cycles.
REQ-017 CNT SHALL be 20 bits and saturate at 20'hFFFFF (no wrap).
REQ-018 POS: HIGH_CNT in [100000,130000) -> 100; [130000,170000] -> 010; (170000,200000] -> 001; otherwise 000.
REQ-019 If CNT reaches TIMEOUT_CYC=600000 in HIGH or LOW: -> IDLE, TIMEOUT=1, POS=000, HIGH_CNT/PERIOD_CNT held, no MEAS_VALID.
REQ-020 A fall seen in IDLE SHALL be ignored; a rise and fall cannot coincide (single sync bit).
REQ-021 Timeout and rise in same cycle: rise wins (normal measurement, TIMEOUT cleared).
REQ-022 Outputs between strobes SHALL hold last values.

Reset
REQ-023 RST=1: state IDLE, CNT=0, HIGH_CNT=0, PERIOD_CNT=0, MEAS_VALID=0, POS=000, TIMEOUT=0, synchronizer/history regs=0, LEVEL=0.
REQ-024 RST mid-measurement SHALL discard partial data; first MEAS_VALID after reset requires a full rise-fall-rise sequence.

Structure
REQ-025 Package pwm_pkg SHALL hold CNT_W=20, TIMEOUT_CYC, POS thresholds, POS encodings, the FSM state enum, and the generator constants L/N/R (high times 110000/150000/190000 cycles) shared with the PWM generator.
REQ-026 One sub-module, sync_edge (2-FF sync + rise/fall detect), SHALL be instantiated; the FSM/counters live in pwm_measure.

Verification
REQ-027 High 150000, period 524288, 3 periods -> MEAS_VALID after 2nd and 3rd rise, HIGH_CNT=150000, PERIOD_CNT=524288, POS=010.
REQ-028 High 110000 then 190000 -> POS=100 then 001; high 90000 -> POS=000, HIGH_CNT=90000.
REQ-029 PWM_IN held low 700000 cycles after one valid cycle -> TIMEOUT=1 at CNT=600000, LEVEL=0, POS=000, counts held; next full cycle clears TIMEOUT.
REQ-030 PWM_IN held high 700000 cycles -> TIMEOUT=1, LEVEL=1, no MEAS_VALID.
REQ-031 RST asserted 1 cycle during HIGH state -> all outputs 0; next rise+fall+rise yields exactly one MEAS_VALID with correct counts.
REQ-032 Pin rise at cycle T -> MEAS_VALID asserted at T+3, deasserted at T+4.
